// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU control encodings, datapath widths, ID/EX slot layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [5:0] {
    OP_SUB = 6'b000000,
    OP_ORI = 6'b000001,
    OP_LW  = 6'b000010,
    OP_SW  = 6'b000011
  } opcode_e;

  typedef enum logic [1:0] {
    ALUOP_NONE  = 2'b00,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ADDOR = 2'b11
  } aluOp_e;

  typedef enum logic [1:0] {
    ALUSRC_REG  = 2'b00,
    ALUSRC_ZEXT = 2'b01,
    ALUSRC_SEXT = 2'b10
  } aluSrc_e;

  typedef struct packed {
    logic       regDst;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memToReg;
    logic [1:0] aluOp;
    logic [1:0] aluSrc;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } exReg_t;

  // A bubble is an all-zero slot: invalid, no side effects, NONE/REG ALU controls.
  localparam exReg_t EX_BUBBLE = '0;

  // rt is a source operand only when it is not the destination (SUB reads rt, SW stores rt).
  function automatic logic usesRt(input logic regDst, input logic memWrite);
    return regDst | memWrite;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register a load in EX writes.
// Latency: purely combinational, same cycle.
// Backpressure: none; its output is what drives the pipeline stall.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic             exValid,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exRt,
  input  logic             idValid,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idRegDst,
  input  logic             idMemWrite,
  output logic             hazard
);

  logic rsMatch;
  logic rtMatch;

  // $0 is never really written, so a load targeting it can never cause a stall.
  always_comb begin
    rsMatch = (exRt == idRs);
    rtMatch = usesRt(idRegDst, idMemWrite) && (exRt == idRt);
    hazard  = exValid && exMemRead && (exRt != '0) && idValid && (rsMatch || rtMatch);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush; counts inserted stall bubbles.
// Latency: one cycle ID to EX; a load-use stall costs exactly one bubble.
// Backpressure: on a hazard pc_write/if_id_write drop combinationally to hold IF and ID.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_reg_dst,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_reg_write,
  input  logic        id_mem_to_reg,
  input  logic [1:0]  id_alu_op,
  input  logic [1:0]  id_alu_src,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        flush,
  output logic        ex_valid,
  output logic        ex_reg_dst,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic [1:0]  ex_alu_op,
  output logic [1:0]  ex_alu_src,
  output logic [31:0] ex_rd1,
  output logic [31:0] ex_rd2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic        pc_write,
  output logic        if_id_write,
  output logic [15:0] bubble_cnt
);

  logic        hazard;
  exReg_t      idSlot;
  exReg_t      exQ;
  logic [15:0] bubbleCnt;

  hazard_detect uHazard (
    .exValid    (exQ.valid),
    .exMemRead  (exQ.ctrl.memRead),
    .exRt       (exQ.rt),
    .idValid    (id_valid),
    .idRs       (id_rs),
    .idRt       (id_rt),
    .idRegDst   (id_reg_dst),
    .idMemWrite (id_mem_write),
    .hazard     (hazard)
  );

  // A flush overrides the stall: the squashed instruction must not hold the front end.
  assign pc_write    = ~hazard | flush;
  assign if_id_write = ~hazard | flush;

  // Assemble the ID slot; side-effect bits are gated so an invalid slot can never write state.
  always_comb begin
    idSlot               = '0;
    idSlot.valid         = id_valid;
    idSlot.ctrl.regDst   = id_reg_dst    & id_valid;
    idSlot.ctrl.memRead  = id_mem_read   & id_valid;
    idSlot.ctrl.memWrite = id_mem_write  & id_valid;
    idSlot.ctrl.regWrite = id_reg_write  & id_valid;
    idSlot.ctrl.memToReg = id_mem_to_reg & id_valid;
    idSlot.ctrl.aluOp    = id_alu_op;
    idSlot.ctrl.aluSrc   = id_alu_src;
    idSlot.rd1           = id_rd1;
    idSlot.rd2           = id_rd2;
    idSlot.imm           = id_imm;
    idSlot.rs            = id_rs;
    idSlot.rt            = id_rt;
    idSlot.rd            = id_rd;
  end

  // Pipeline register: flush or hazard loads a bubble, otherwise capture the ID slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exQ <= EX_BUBBLE;
    end else if (flush || hazard) begin
      exQ <= EX_BUBBLE;
    end else begin
      exQ <= idSlot;
    end
  end

  // Saturating count of stall bubbles; flush bubbles are not stalls and are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubbleCnt <= '0;
    end else if (hazard && !flush && (bubbleCnt != 16'hFFFF)) begin
      bubbleCnt <= bubbleCnt + 16'd1;
    end
  end

  assign ex_valid      = exQ.valid;
  assign ex_reg_dst    = exQ.ctrl.regDst;
  assign ex_mem_read   = exQ.ctrl.memRead;
  assign ex_mem_write  = exQ.ctrl.memWrite;
  assign ex_reg_write  = exQ.ctrl.regWrite;
  assign ex_mem_to_reg = exQ.ctrl.memToReg;
  assign ex_alu_op     = exQ.ctrl.aluOp;
  assign ex_alu_src    = exQ.ctrl.aluSrc;
  assign ex_rd1        = exQ.rd1;
  assign ex_rd2        = exQ.rd2;
  assign ex_imm        = exQ.imm;
  assign ex_rs         = exQ.rs;
  assign ex_rt         = exQ.rt;
  assign ex_rd         = exQ.rd;
  assign bubble_cnt    = bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed table, hand-written corner sequences, randomized run vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic [1:0]  id_alu_op, id_alu_src;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush;
  logic        ex_valid, ex_reg_dst, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [1:0]  ex_alu_op, ex_alu_src;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        pc_write, if_id_write;
  logic [15:0] bubble_cnt;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg_dst(id_reg_dst),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .flush(flush), .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .pc_write(pc_write), .if_id_write(if_id_write), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  localparam int SUB = 0, ORI = 1, LW = 2, SW = 3;

  // One instruction slot; same layout is used for ID stimulus and the modelled EX contents.
  typedef struct packed {
    logic        valid;
    logic        regDst, memRead, memWrite, regWrite, memToReg;
    logic [1:0]  aluOp, aluSrc;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } slot_t;

  typedef struct {
    int   prevOp; int prevRt;
    int   curOp;  int curRs; int curRt;
    logic curValid; logic fl;
    logic expPc; logic expValid; int expInc;
  } vec_t;

  slot_t       mEx;
  logic [15:0] mCnt;
  logic        pcSeen;
  int          passCnt = 0;
  int          totalCnt = 0;
  vec_t        tbl [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Instruction encoder: control bits as the control unit would decode each opcode.
  function automatic slot_t mkInst(input int op, input int rs, input int rt, input int rd,
                                   input logic v);
    slot_t s;
    s = '0;
    s.valid = v;
    s.rs = rs[4:0]; s.rt = rt[4:0]; s.rd = rd[4:0];
    s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom;
    case (op)
      SUB: begin s.regDst = 1; s.regWrite = 1; s.aluOp = 2'b10; s.aluSrc = 2'b00; end
      ORI: begin s.regWrite = 1; s.aluOp = 2'b11; s.aluSrc = 2'b01; end
      LW:  begin s.memRead = 1; s.regWrite = 1; s.memToReg = 1; s.aluOp = 2'b11; s.aluSrc = 2'b10; end
      default: begin s.memWrite = 1; s.aluOp = 2'b11; s.aluSrc = 2'b10; end
    endcase
    return s;
  endfunction

  // Load-use rule: a valid load in EX whose nonzero target is a source of the ID instruction.
  function automatic logic modelHazard(input slot_t s);
    logic readsRt;
    readsRt = s.regDst || s.memWrite;
    return mEx.valid && mEx.memRead && (mEx.rt != 0) && s.valid &&
           ((mEx.rt == s.rs) || (readsRt && mEx.rt == s.rt));
  endfunction

  task automatic drive(input slot_t s, input logic f);
    id_valid = s.valid; id_reg_dst = s.regDst; id_mem_read = s.memRead;
    id_mem_write = s.memWrite; id_reg_write = s.regWrite; id_mem_to_reg = s.memToReg;
    id_alu_op = s.aluOp; id_alu_src = s.aluSrc; id_rd1 = s.rd1; id_rd2 = s.rd2;
    id_imm = s.imm; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; flush = f;
  endtask

  function automatic slot_t dutEx();
    return {ex_valid, ex_reg_dst, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
            ex_alu_op, ex_alu_src, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd};
  endfunction

  // Present one ID slot for one clock; check stall outputs before the edge, EX state after.
  task automatic step(input slot_t s, input logic f);
    logic  haz, expPc;
    slot_t nxt;
    @(negedge clk);
    drive(s, f);
    #1;
    haz    = modelHazard(s);
    expPc  = !haz || f;
    pcSeen = pc_write;
    check("pc_if_id_write", {126'd0, pc_write, if_id_write}, {126'd0, expPc, expPc});
    if (f || haz) nxt = '0;
    else begin
      nxt = s;
      if (!s.valid) {nxt.regDst, nxt.memRead, nxt.memWrite, nxt.regWrite, nxt.memToReg} = '0;
    end
    @(posedge clk);
    #1;
    mEx = nxt;
    if (haz && !f && mCnt != 16'hFFFF) mCnt = mCnt + 1;
    check("ex_slot", {7'd0, dutEx()}, {7'd0, mEx});
    check("bubble_cnt", {112'd0, bubble_cnt}, {112'd0, mCnt});
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge arrives.
  task automatic doReset();
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_ex_zero", {7'd0, dutEx()}, 128'd0);
    check("rst_cnt_zero", {112'd0, bubble_cnt}, 128'd0);
    check("rst_pc_write", {126'd0, pc_write, if_id_write}, {126'd0, 2'b11});
    mEx = '0; mCnt = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int runCnt;
    rst_n = 0;
    drive('0, 1'b0);
    mEx = '0; mCnt = 0;

    //           prevOp prevRt curOp curRs curRt valid flush  pc valid inc
    tbl[0]  = '{LW,  3, SUB, 3, 7, 1, 0, 0, 0, 1};
    tbl[1]  = '{LW,  3, SUB, 1, 3, 1, 0, 0, 0, 1};
    tbl[2]  = '{LW,  3, ORI, 5, 3, 1, 0, 1, 1, 0};
    tbl[3]  = '{LW,  0, SUB, 0, 0, 1, 0, 1, 1, 0};
    tbl[4]  = '{LW,  4, SW,  9, 4, 1, 1, 1, 0, 0};
    tbl[5]  = '{SUB, 3, SUB, 3, 1, 1, 0, 1, 1, 0};
    tbl[6]  = '{LW,  6, LW,  6, 2, 1, 0, 0, 0, 1};
    tbl[7]  = '{LW,  6, LW,  1, 6, 1, 0, 1, 1, 0};
    tbl[8]  = '{LW,  8, SW,  2, 8, 1, 0, 0, 0, 1};
    tbl[9]  = '{LW,  5, SUB, 5, 1, 0, 0, 1, 0, 0};
    tbl[10] = '{SUB, 2, ORI, 1, 1, 1, 1, 1, 0, 0};

    #2;
    check("init_ex_zero", {7'd0, dutEx()}, 128'd0);
    check("init_cnt", {112'd0, bubble_cnt}, 128'd0);
    check("init_pc_write", {126'd0, pc_write, if_id_write}, {126'd0, 2'b11});
    @(negedge clk);
    rst_n = 1;

    // Directed table
    runCnt = 0;
    for (int i = 0; i < 11; i++) begin
      step(mkInst(tbl[i].prevOp, 0, tbl[i].prevRt, 7, 1'b1), 1'b0);
      step(mkInst(tbl[i].curOp, tbl[i].curRs, tbl[i].curRt, 9, tbl[i].curValid), tbl[i].fl);
      runCnt += tbl[i].expInc;
      check($sformatf("tbl%0d_pc", i), {127'd0, pcSeen}, {127'd0, tbl[i].expPc});
      check($sformatf("tbl%0d_valid", i), {127'd0, ex_valid}, {127'd0, tbl[i].expValid});
      check($sformatf("tbl%0d_cnt", i), {112'd0, bubble_cnt}, 128'(runCnt));
    end

    // Load-use stall then the held SUB is captured
    doReset();
    step(mkInst(LW, 0, 3, 0, 1'b1), 1'b0);
    step(mkInst(SUB, 3, 1, 2, 1'b1), 1'b0);
    check("lu_pc_low", {127'd0, pcSeen}, 128'd0);
    check("lu_bubble_valid", {127'd0, ex_valid}, 128'd0);
    check("lu_cnt_one", {112'd0, bubble_cnt}, 128'd1);
    step(mkInst(SUB, 3, 1, 2, 1'b1), 1'b0);
    check("lu_resume_pc", {127'd0, pcSeen}, 128'd1);
    check("lu_resume_capture", {126'd0, ex_valid, ex_reg_write}, {126'd0, 2'b11});

    // Flush and hazard together
    doReset();
    step(mkInst(LW, 0, 4, 0, 1'b1), 1'b0);
    step(mkInst(SW, 1, 4, 0, 1'b1), 1'b1);
    check("fh_pc_high", {127'd0, pcSeen}, 128'd1);
    check("fh_bubble", {126'd0, ex_valid, ex_mem_write}, 128'd0);
    check("fh_cnt_same", {112'd0, bubble_cnt}, 128'd0);

    // Saturation: preload the counter near the top, then stall repeatedly
    doReset();
    @(negedge clk);
    force dut.bubbleCnt = 16'hFFFC;
    #1;
    release dut.bubbleCnt;
    mCnt = 16'hFFFC;
    for (int i = 0; i < 6; i++) begin
      step(mkInst(LW, 0, 3, 0, 1'b1), 1'b0);
      step(mkInst(SUB, 3, 3, 1, 1'b1), 1'b0);
    end
    check("sat_cnt", {112'd0, bubble_cnt}, {112'd0, 16'hFFFF});

    // Reset with a live writing instruction in EX, then normal capture on release
    step(mkInst(SUB, 1, 2, 3, 1'b1), 1'b0);
    check("pre_rst_live", {126'd0, ex_valid, ex_reg_write}, {126'd0, 2'b11});
    doReset();
    step(mkInst(ORI, 2, 6, 0, 1'b1), 1'b0);
    check("post_rst_capture", {127'd0, ex_valid}, 128'd1);

    // Randomized run against the model, small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      step(mkInst($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 31), $urandom_range(0, 9) != 0),
           $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 id_valid  in  1  ID holds a real instruction.
REQ-004 id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  decoded control bits from the control unit.
REQ-005 id_alu_op  in  2; id_alu_src  in  2  decoded ALU controls.
REQ-006 id_rd1, id_rd2  in  32  register-file read data.
REQ-007 id_imm  in  32  sign-extended immediate.
REQ-008 id_rs, id_rt, id_rd  in  5  register specifiers.
REQ-009 flush  in  1  squash the ID instruction (branch/exception).
REQ-010 ex_valid, ex_reg_dst, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each  registered copies.
REQ-011 ex_alu_op, ex_alu_src  out  2; ex_rd1, ex_rd2, ex_imm  out  32; ex_rs, ex_rt, ex_rd  out  5  registered copies.
REQ-012 pc_write  out  1  0 = freeze PC (combinational).
REQ-013 if_id_write  out  1  0 = freeze IF/ID register (combinational).
REQ-014 bubble_cnt  out  16  saturating count of inserted bubbles.

Function
REQ-015 uses_rt = id_reg_dst | id_mem_write (SUB, SW read rt; ORI, LW write it).
REQ-016 hazard = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
REQ-017 pc_write = if_id_write = ~hazard | flush; same-cycle, no register.
REQ-018 Each edge, priority: flush > hazard > capture.
REQ-019 flush or hazard: load bubble -- ex_valid and all ex_ control bits 0, ex_alu_op = 00, ex_alu_src = 00, data and specifiers 0.
REQ-020 Capture: every ex_ output takes its id_ counterpart; ex_valid = id_valid.
REQ-021 id_valid = 0 without flush/hazard: captured as-is; control bits forced 0 so invalid slots never write memory or registers.
REQ-022 Latency: one cycle ID to EX; load-use stall is exactly one cycle (bubble clears ex_mem_read, hazard drops next cycle).
REQ-023 bubble_cnt increments by 1 per edge that loads a hazard bubble (not flush); holds at 16'hFFFF.
REQ-024 Simultaneous flush and hazard: flush bubble, pc_write = 1, bubble_cnt unchanged.
REQ-025 ex_rt = 0: never a hazard, even for LW to $0.

Reset
REQ-026 rst_n low: all ex_ outputs 0, ex_valid 0, bubble_cnt 0, immediately regardless of clk.
REQ-027 Thus pc_write = if_id_write = 1 during and after reset.
REQ-028 Reset deassertion mid-stream: first edge after release performs normal capture.

Structure
REQ-029 Shared package cpu_pkg: opcodes (SUB 000000, ORI 000001, LW 000010, SW 000011), ALUOp codes (00 none, 10 R-type, 11 add/or-imm), ALUSrc codes (00 reg, 01 zero-ext imm, 10 sign-ext imm), widths 32/5.
REQ-030 One sub-module hazard_detect: purely combinational, computes hazard from REQ-016; register stage in top.

Verification
REQ-031 LW $3 (ex_rt=3) in EX, SUB id_rs=3 -> hazard, pc_write=0, next edge bubble, ex_valid=0, bubble_cnt=1; following cycle SUB captured.
REQ-032 LW $3 in EX, ORI id_rs=5 id_rt=3 -> no hazard (rt is destination), ORI captured, pc_write=1.
REQ-033 LW $0 in EX, SUB id_rs=0 -> no hazard, SUB captured.
REQ-034 LW $4 in EX, SW id_rt=4, flush=1 same cycle -> pc_write=1, bubble loaded, bubble_cnt unchanged.
REQ-035 Force 65536 hazard bubbles -> bubble_cnt stays 16'hFFFF.
REQ-036 rst_n low mid-stream with ex_reg_write=1, ex_valid=1 -> outputs 0 before next clk edge, pc_write=1.
